// File: rtl/rf_sched_pkg.sv
// Shared types for the register-file write-side scheduler.
package rf_sched_pkg;

  localparam int TAG_W = 3;

  // One buffered ROB commit waiting for the regfile write port.
  typedef struct packed {
    logic [4:0]       dest;
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } cmt_entry_t;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    FIXUP = 1'b1
  } sched_state_t;

endpackage

// File: rtl/rf_cmt_fifo.sv
// Small synchronous FIFO of commit entries with occupancy count and flags.
module rf_cmt_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  rf_sched_pkg::cmt_entry_t     din,
  input  logic                         pop,
  output rf_sched_pkg::cmt_entry_t     head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  import rf_sched_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  cmt_entry_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage array; contents are don't-care until written so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/rf_write_sched.sv
// Serializes ROB commits and dispatch allocations onto the single regfile
// write-control port, repairing commits that land on already-renamed registers.
module rf_write_sched #(
  parameter int CMT_DEPTH  = 4,
  parameter int STARVE_MAX = 4,
  parameter int TAG_W      = 3   // must equal rf_sched_pkg::TAG_W (entry tag width)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmt_valid,
  output logic                           cmt_ready,
  input  logic [4:0]                     cmt_dest,
  input  logic [31:0]                    cmt_data,
  input  logic [TAG_W-1:0]               cmt_tag,
  input  logic                           alloc_valid,
  output logic                           alloc_ready,
  input  logic [4:0]                     alloc_dest,
  input  logic [TAG_W-1:0]               alloc_tag,
  output logic                           rf_load,
  output logic                           rf_allocate,
  output logic [4:0]                     rf_dest,
  output logic [31:0]                    rf_in,
  output logic [TAG_W-1:0]               rf_tag_in,
  input  logic [TAG_W-1:0]               rf_tag_dest,
  output logic                           fixup_active,
  output logic [$clog2(CMT_DEPTH+1)-1:0] cmt_count
);
  import rf_sched_pkg::*;

  localparam int CW = $clog2(CMT_DEPTH+1);
  localparam int SW = $clog2(STARVE_MAX+1);

  sched_state_t     state;
  logic [SW-1:0]    starve_cnt;
  logic [4:0]       fixup_dest;
  logic [TAG_W-1:0] fixup_tag;

  cmt_entry_t    head, din;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic          push, cmt_grant, alloc_grant, c_pend, a_pend;

  assign din    = '{dest: cmt_dest, data: cmt_data, tag: cmt_tag};
  // Writes to x0 are architecturally dropped, so they never occupy a slot.
  assign push   = cmt_valid && cmt_ready && (cmt_dest != 5'd0);
  assign c_pend = !fifo_empty;
  assign a_pend = alloc_valid && (alloc_dest != 5'd0);

  rf_cmt_fifo #(.DEPTH(CMT_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (din),
    .pop   (cmt_grant),
    .head  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Arbitration and regfile drive; every output is forced low while rst is high.
  always_comb begin
    cmt_grant    = 1'b0;
    alloc_grant  = 1'b0;
    cmt_ready    = 1'b0;
    alloc_ready  = 1'b0;
    rf_load      = 1'b0;
    rf_allocate  = 1'b0;
    rf_dest      = 5'd0;
    rf_in        = 32'd0;
    rf_tag_in    = '0;
    fixup_active = 1'b0;
    cmt_count    = '0;
    if (!rst) begin
      cmt_ready = !fifo_full;
      cmt_count = fifo_count;
      if (state == ARB) begin
        if (c_pend && (!a_pend || starve_cnt < SW'(STARVE_MAX))) cmt_grant = 1'b1;
        else if (a_pend)                                          alloc_grant = 1'b1;
        alloc_ready = alloc_valid && ((alloc_dest == 5'd0) || alloc_grant);
        if (cmt_grant) begin
          rf_load = 1'b1;
          rf_dest = head.dest;
          rf_in   = head.data;
        end else if (alloc_grant) begin
          rf_allocate = 1'b1;
          rf_dest     = alloc_dest;
          rf_tag_in   = alloc_tag;
        end
      end else begin
        // Commit just set valid on a renamed register; put it back to busy.
        fixup_active = 1'b1;
        rf_allocate  = 1'b1;
        rf_dest      = fixup_dest;
        rf_tag_in    = fixup_tag;
      end
    end
  end

  // FSM, starvation counter and fixup capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB;
      starve_cnt <= '0;
      fixup_dest <= 5'd0;
      fixup_tag  <= '0;
    end else begin
      case (state)
        ARB: begin
          if (a_pend && cmt_grant)
            starve_cnt <= (starve_cnt == SW'(STARVE_MAX)) ? starve_cnt : starve_cnt + SW'(1);
          else
            starve_cnt <= '0;
          if (cmt_grant && (rf_tag_dest != head.tag)) begin
            fixup_dest <= head.dest;
            fixup_tag  <= rf_tag_dest;
            state      <= FIXUP;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_write_sched.sv
// Directed bench for rf_write_sched with an ordered scoreboard of regfile ops.
module tb_rf_write_sched;
  import rf_sched_pkg::*;

  localparam int TW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmt_valid, cmt_ready;
  logic [4:0]    cmt_dest;
  logic [31:0]   cmt_data;
  logic [TW-1:0] cmt_tag;
  logic          alloc_valid, alloc_ready;
  logic [4:0]    alloc_dest;
  logic [TW-1:0] alloc_tag;
  logic          rf_load, rf_allocate;
  logic [4:0]    rf_dest;
  logic [31:0]   rf_in;
  logic [TW-1:0] rf_tag_in, rf_tag_dest;
  logic          fixup_active;
  logic [2:0]    cmt_count;

  logic [TW-1:0] tb_tag [32];
  assign rf_tag_dest = tb_tag[rf_dest];

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          is_alloc;
    logic [4:0]  dest;
    logic [31:0] val;
  } op_t;
  op_t exq[$];

  rf_write_sched #(.CMT_DEPTH(4), .STARVE_MAX(4), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_dest(cmt_dest),
    .cmt_data(cmt_data), .cmt_tag(cmt_tag),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_dest(alloc_dest), .alloc_tag(alloc_tag),
    .rf_load(rf_load), .rf_allocate(rf_allocate), .rf_dest(rf_dest),
    .rf_in(rf_in), .rf_tag_in(rf_tag_in), .rf_tag_dest(rf_tag_dest),
    .fixup_active(fixup_active), .cmt_count(cmt_count)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pack_op(logic ld, logic al, logic [4:0] d, logic [31:0] v);
    return {25'd0, ld, al, d, v};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expl(input logic [4:0] d, input logic [31:0] v);
    exq.push_back('{is_alloc: 1'b0, dest: d, val: v});
  endtask

  task automatic expa(input logic [4:0] d, input logic [TW-1:0] t);
    exq.push_back('{is_alloc: 1'b1, dest: d, val: 32'(t)});
  endtask

  task automatic drv_cmt(input logic v, input logic [4:0] d, input logic [31:0] x, input logic [TW-1:0] t);
    cmt_valid = v; cmt_dest = d; cmt_data = x; cmt_tag = t;
  endtask

  task automatic drv_alloc(input logic v, input logic [4:0] d, input logic [TW-1:0] t);
    alloc_valid = v; alloc_dest = d; alloc_tag = t;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every regfile op must match the next expected op in order.
  op_t         m_e;
  logic [63:0] m_o;
  always @(negedge clk) begin
    if (rf_load || rf_allocate) begin
      m_o = pack_op(rf_load, rf_allocate, rf_dest, rf_load ? rf_in : 32'(rf_tag_in));
      tests++;
      if (exq.size() == 0) begin
        fails++;
        $error("FAIL sb_unexpected observed=%0h expected=none", m_o);
      end else begin
        m_e = exq.pop_front();
        assert (m_o === pack_op(!m_e.is_alloc, m_e.is_alloc, m_e.dest, m_e.val)) else begin
          fails++;
          $error("FAIL sb_op observed=%0h expected=%0h", m_o,
                 pack_op(!m_e.is_alloc, m_e.is_alloc, m_e.dest, m_e.val));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int saw_full;
    foreach (tb_tag[i]) tb_tag[i] = '0;

    // Reset cycle: requests present but everything must stay low.
    rst = 1'b1;
    drv_cmt(1'b1, 5'd5, 32'h1111, 3'd0);
    drv_alloc(1'b1, 5'd3, 3'd1);
    #1;
    chk("rst_cmt_ready",   cmt_ready,    0);
    chk("rst_alloc_ready", alloc_ready,  0);
    chk("rst_rf_ops",      {rf_load, rf_allocate}, 0);
    chk("rst_count",       cmt_count,    0);
    chk("rst_fixup",       fixup_active, 0);
    cyc();
    rst = 1'b0;
    drv_cmt(1'b0, 5'd0, 32'd0, 3'd0);
    drv_alloc(1'b0, 5'd0, 3'd0);

    // Matching commit: no fixup.
    tb_tag[5] = 3'd3;
    drv_cmt(1'b1, 5'd5, 32'hDEADBEEF, 3'd3);
    #1;
    chk("m_ready", cmt_ready, 1);
    expl(5'd5, 32'hDEADBEEF);
    cyc();
    drv_cmt(1'b0, 5'd0, 32'd0, 3'd0);
    #1;
    chk("m_c1_load", {rf_load, rf_dest, rf_in}, {1'b1, 5'd5, 32'hDEADBEEF});
    cyc(); #1;
    chk("m_c2_alloc", rf_allocate,  0);
    chk("m_c2_fixup", fixup_active, 0);
    chk("m_c2_count", cmt_count,    0);

    // Stale commit: x7 renamed to tag 6, commit carries tag 2.
    tb_tag[7] = 3'd6;
    drv_cmt(1'b1, 5'd7, 32'h1234, 3'd2);
    expl(5'd7, 32'h1234);
    expa(5'd7, 3'd6);
    cyc();
    drv_cmt(1'b0, 5'd0, 32'd0, 3'd0);
    drv_alloc(1'b1, 5'd9, 3'd4);
    expa(5'd9, 3'd4);
    #1;
    chk("s_c1_load", {rf_load, rf_dest}, {1'b1, 5'd7});
    chk("s_c1_aready", alloc_ready, 0);
    cyc(); #1;
    chk("s_c2_fixup", {rf_allocate, rf_dest, rf_tag_in, fixup_active}, {1'b1, 5'd7, 3'd6, 1'b1});
    chk("s_c2_aready", alloc_ready, 0);
    cyc(); #1;
    chk("s_c3_alloc", {rf_allocate, rf_dest, rf_tag_in, alloc_ready}, {1'b1, 5'd9, 3'd4, 1'b1});
    cyc();
    drv_alloc(1'b0, 5'd0, 3'd0);

    // Starvation guard: four commits win, then the held allocate.
    for (int i = 0; i < 4; i++) expl(5'(10 + i), 32'hA0 + 32'(i));
    expa(5'd3, 3'd1);
    expl(5'd14, 32'hA4);
    expl(5'd15, 32'hA5);
    for (int i = 0; i < 8; i++) begin
      if (i < 6) drv_cmt(1'b1, 5'(10 + i), 32'hA0 + 32'(i), 3'd0);
      else       drv_cmt(1'b0, 5'd0, 32'd0, 3'd0);
      drv_alloc((i >= 1 && i <= 5), 5'd3, 3'd1);
      #1;
      if (i >= 1 && i <= 4) chk("st_cmt_win", {rf_load, alloc_ready}, {1'b1, 1'b0});
      if (i == 5) chk("st_alloc_win", {rf_allocate, rf_dest, alloc_ready}, {1'b1, 5'd3, 1'b1});
      if (i == 6) chk("st_cnt_clear", 64'(dut.starve_cnt), 0);
      if (i >= 6) chk("st_drain_load", rf_load, 1);
      cyc();
    end
    drv_cmt(1'b0, 5'd0, 32'd0, 3'd0);
    drv_alloc(1'b0, 5'd0, 3'd0);
    #1;
    chk("st_count_end", cmt_count, 0);

    // FIFO full: stale commits back-to-back, each held until accepted.
    for (int i = 20; i < 28; i++) tb_tag[i] = 3'd5;
    saw_full = 0;
    for (int i = 0; i < 8; i++) begin
      drv_cmt(1'b1, 5'(20 + i), 32'h100 + 32'(i), 3'd2);
      #1;
      guard = 0;
      while (!cmt_ready && guard < 20) begin
        saw_full = 1;
        chk("full_count", cmt_count, 4);
        cyc(); #1;
        guard++;
      end
      if (!cmt_ready) chk("full_ready_timeout", cmt_ready, 1);
      expl(5'(20 + i), 32'h100 + 32'(i));
      expa(5'(20 + i), 3'd5);
      cyc();
    end
    drv_cmt(1'b0, 5'd0, 32'd0, 3'd0);
    chk("full_seen", saw_full, 1);
    guard = 0;
    #1;
    while ((cmt_count != 0 || fixup_active) && guard < 40) begin
      cyc(); #1;
      guard++;
    end
    chk("full_drain_count", cmt_count, 0);
    chk("full_sb_empty", exq.size(), 0);

    // x0 commit and x0 allocate together: both accepted, no regfile op.
    drv_cmt(1'b1, 5'd0, 32'h55, 3'd0);
    drv_alloc(1'b1, 5'd0, 3'd2);
    #1;
    chk("x0_handshakes", {cmt_ready, alloc_ready}, {1'b1, 1'b1});
    chk("x0_no_op", {rf_load, rf_allocate}, 0);
    cyc();
    drv_cmt(1'b0, 5'd0, 32'd0, 3'd0);
    drv_alloc(1'b0, 5'd0, 3'd0);
    #1;
    chk("x0_count", cmt_count, 0);

    // Reset during FIXUP abandons the fixup and the buffered commit.
    drv_cmt(1'b1, 5'd7, 32'h77, 3'd1);
    expl(5'd7, 32'h77);
    cyc();
    drv_cmt(1'b1, 5'd5, 32'h55, 3'd3);
    #1;
    chk("rf_c1_load", {rf_load, rf_dest}, {1'b1, 5'd7});
    cyc();
    drv_cmt(1'b0, 5'd0, 32'd0, 3'd0);
    rst = 1'b1;
    #1;
    chk("rf_rst_outs", {fixup_active, rf_allocate, cmt_ready}, 0);
    cyc();
    rst = 1'b0;
    #1;
    chk("rf_after_alloc", rf_allocate,  0);
    chk("rf_after_fixup", fixup_active, 0);
    chk("rf_after_count", cmt_count,    0);
    chk("rf_after_state", 64'(dut.state), 64'(ARB));
    cyc(); cyc(); #1;
    chk("final_sb_empty", exq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
